// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - funct3 codes and FSM state type shared by the responder
package data_memory_responder_pkg;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_lsu_align.sv
// rtl/data_memory_responder_lsu_align.sv - byte-lane steering, load extension and access checks
module lsu_align
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        error
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] shifted;

  assign out_of_range = {2'b00, addr[31:2]} >= $unsigned(DEPTH_WORDS);
  assign error        = illegal | misaligned | out_of_range;
  assign shifted      = rdata_word >> {addr[1:0], 3'b000};

  // Classify funct3 legality and natural alignment of the access
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (write) begin
      illegal = (funct3 > F3_SW);
    end else begin
      illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (funct3[1:0])
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed bytes
  always_comb begin
    wstrb       = 4'b0000;
    wdata_lanes = wdata;
    if (write && !error) begin
      case (funct3)
        F3_SB: begin
          wstrb       = 4'b0001 << addr[1:0];
          wdata_lanes = {4{wdata[7:0]}};
        end
        F3_SH: begin
          wstrb       = addr[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
        end
        F3_SW:   wstrb = 4'b1111;
        default: wstrb = 4'b0000;
      endcase
    end
  end

  // Pick the addressed bytes out of the word and sign/zero extend them
  always_comb begin
    load_data = 32'h0;
    if (!write && !error) begin
      case (funct3)
        F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
        F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
        F3_LW:   load_data = shifted;
        F3_LBU:  load_data = {24'h0, shifted[7:0]};
        F3_LHU:  load_data = {16'h0, shifted[15:0]};
        default: load_data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - single-outstanding RV32I data memory with fixed access latency
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        commit;

  logic        cap_write;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_addr, cap_wdata;

  logic        op_write;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic [IDX_W-1:0] op_idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word_rd;
  logic [3:0]  wstrb;
  logic [31:0] wdata_lanes;
  logic [31:0] load_data;
  logic        op_error;

  logic [31:0] rdata_q;
  logic        error_q;

  // With zero latency the access commits in the accept cycle, before capture
  assign op_write  = (state == ST_IDLE) ? req_write  : cap_write;
  assign op_funct3 = (state == ST_IDLE) ? req_funct3 : cap_funct3;
  assign op_addr   = (state == ST_IDLE) ? req_addr   : cap_addr;
  assign op_wdata  = (state == ST_IDLE) ? req_wdata  : cap_wdata;
  assign op_idx    = op_addr[IDX_W+1:2];
  assign word_rd   = mem[op_idx];

  lsu_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_align (
    .write      (op_write),
    .funct3     (op_funct3),
    .addr       (op_addr),
    .wdata      (op_wdata),
    .rdata_word (word_rd),
    .wstrb      (wstrb),
    .wdata_lanes(wdata_lanes),
    .load_data  (load_data),
    .error      (op_error)
  );

  // State and latency counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, commit strobe and handshake/response outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_error = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_error = error_q;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write  <= 1'b0;
      cap_funct3 <= 3'd0;
      cap_addr   <= 32'h0;
      cap_wdata  <= 32'h0;
    end else if (req_valid && state == ST_IDLE) begin
      cap_write  <= req_write;
      cap_funct3 <= req_funct3;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  // Latch the response on the edge that enters RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else if (commit) begin
      rdata_q <= load_data;
      error_q <= op_error;
    end
  end

  // Storage is never reset; byte enables are already zero for loads and errors
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[op_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

endmodule
